led_stream_rx: RTL and testbench

- Receiver/decoder for the 3-wire LED shift-register stream (LED_CLK, LED_OUT, LED_OE) driven by the front-panel LED driver.
- Oversamples the stream on a fast system clock and reassembles each 24-bit frame.
- De-interleaves each frame back into the 12-bit trigger mask and the 4-bit JTAG mux select.
- Used for on-board readback of the panel state and as the checker in the LED-path self-test.

---
 rtl/led_stream_rx.sv | 269 ++++++++++++++++++++++++++
 tb/tb_led_stream_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : led_stream_rx
// Description : Receiver/decoder for the 3-wire front-panel LED shift stream
//               (LED_CLK, LED_OUT, LED_OE). Oversamples the stream on CLK,
//               reassembles each frame, then splits it into the 12-bit
//               trigger mask and the 4-bit JTAG mux select.
//
// Ports       : CLK          system clock (>= 8x LED_CLK rate)
//               RST          asynchronous active-high reset
//               LED_CLK      serial bit clock  (async to CLK)
//               LED_OUT      serial data       (async to CLK)
//               LED_OE       frame envelope    (async to CLK)
//               DATA_OUT     last good raw frame, first bit received = MSB
//               TRG_MASK_OUT de-interleaved trigger mask
//               JTAG_MUX_OUT decoded mux select (15 = all / illegal)
//               VALID        one-cycle pulse, good frame latched
//               FRAME_ERR    one-cycle pulse, short/long/aborted frame
//               MUX_ERR      level, last good frame held an illegal mux code
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_stream_rx #(
    parameter int FRAME_BITS = 24,   // de-interleave mapping assumes 24
    parameter int TIMEOUT    = 1023
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LED_CLK,
    input  logic        LED_OUT,
    input  logic        LED_OE,
    output logic [23:0] DATA_OUT,
    output logic [11:0] TRG_MASK_OUT,
    output logic [3:0]  JTAG_MUX_OUT,
    output logic        VALID,
    output logic        FRAME_ERR,
    output logic        MUX_ERR
);

    localparam int c_CNT_W = $clog2(FRAME_BITS + 2);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronisers: meta -> sync -> history for each line
    // ------------------------------------------------------------------------
    logic r_clk_meta, r_clk_sync, r_clk_hist;
    logic r_oe_meta,  r_oe_sync,  r_oe_hist;
    logic r_out_meta, r_out_sync, r_out_hist;

    // Edge events are registered once more; r_out_hist lines up with them so
    // the data bit captured belongs to the same LED_CLK rising edge.
    logic r_clk_rise, r_oe_rise, r_oe_fall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_clk_meta <= 1'b0;
            r_clk_sync <= 1'b0;
            r_clk_hist <= 1'b0;
            r_oe_meta  <= 1'b0;
            r_oe_sync  <= 1'b0;
            r_oe_hist  <= 1'b0;
            r_out_meta <= 1'b0;
            r_out_sync <= 1'b0;
            r_out_hist <= 1'b0;
            r_clk_rise <= 1'b0;
            r_oe_rise  <= 1'b0;
            r_oe_fall  <= 1'b0;
        end else begin
            r_clk_meta <= LED_CLK;
            r_clk_sync <= r_clk_meta;
            r_clk_hist <= r_clk_sync;
            r_oe_meta  <= LED_OE;
            r_oe_sync  <= r_oe_meta;
            r_oe_hist  <= r_oe_sync;
            r_out_meta <= LED_OUT;
            r_out_sync <= r_out_meta;
            r_out_hist <= r_out_sync;
            r_clk_rise <= r_clk_sync & ~r_clk_hist;
            r_oe_rise  <= r_oe_sync & ~r_oe_hist;
            r_oe_fall  <= ~r_oe_sync & r_oe_hist;
        end
    end

    // ------------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [23:0]          r_shift;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [23:0]          r_data;
    logic [11:0]          r_trg;
    logic [3:0]           r_sel;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_muxerr;

    state_t               w_state_nxt;
    logic [23:0]          w_shift_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_TO_W-1:0]    w_to_nxt;
    logic [23:0]          w_data_nxt;
    logic [11:0]          w_trg_nxt;
    logic [3:0]           w_sel_nxt;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;
    logic                 w_muxerr_nxt;

    // ------------------------------------------------------------------------
    // De-interleave: each byte of the frame carries four (trigger, mux) pairs,
    // trigger bit first, lowest index in the most significant pair.
    // ------------------------------------------------------------------------
    logic [11:0] w_trg;
    logic [11:0] w_mux;

    genvar g, k;
    generate
        for (g = 0; g < 3; g++) begin : g_grp
            for (k = 0; k < 4; k++) begin : g_pos
                assign w_trg[4*g+k] = r_shift[8*g+7-2*k];
                assign w_mux[4*g+k] = r_shift[8*g+6-2*k];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Mux decode: one-hot -> index, all-ones -> 15 (broadcast), else illegal
    // ------------------------------------------------------------------------
    logic [3:0] w_ones;
    logic [3:0] w_sel;
    logic       w_mux_err;

    always_comb begin
        w_ones    = 4'd0;
        w_sel     = 4'd15;
        w_mux_err = 1'b1;
        for (int n = 0; n < 12; n++) begin
            w_ones = w_ones + {3'b000, w_mux[n]};
        end
        if (w_mux == 12'hFFF) begin
            w_mux_err = 1'b0;
        end else if (w_ones == 4'd1) begin
            w_mux_err = 1'b0;
            for (int n = 0; n < 12; n++) begin
                if (w_mux[n]) begin
                    w_sel = 4'(n);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_shift   <= 24'd0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_data    <= 24'd0;
            r_trg     <= 12'd0;
            r_sel     <= 4'd0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_muxerr  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_to_cnt  <= w_to_nxt;
            r_data    <= w_data_nxt;
            r_trg     <= w_trg_nxt;
            r_sel     <= w_sel_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
            r_muxerr  <= w_muxerr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_bit_cnt;
        w_to_nxt     = r_to_cnt;
        w_data_nxt   = r_data;
        w_trg_nxt    = r_trg;
        w_sel_nxt    = r_sel;
        w_muxerr_nxt = r_muxerr;
        w_valid_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_oe_rise) begin
                    w_shift_nxt = 24'd0;
                    w_cnt_nxt   = '0;
                    w_to_nxt    = '0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // A bit edge coincident with the envelope closing is kept.
                if (r_clk_rise) begin
                    w_shift_nxt = {r_shift[22:0], r_out_hist};
                    w_to_nxt    = '0;
                    if (r_bit_cnt != c_CNT_W'(FRAME_BITS + 1)) begin
                        w_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                    end
                end
                if (r_oe_fall) begin
                    w_state_nxt = S_CHECK;
                end else if (!r_clk_rise) begin
                    if (r_to_cnt == c_TO_W'(TIMEOUT)) begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_to_nxt = r_to_cnt + c_TO_W'(1);
                    end
                end
            end

            S_CHECK: begin
                if (r_bit_cnt == c_CNT_W'(FRAME_BITS)) begin
                    w_data_nxt   = r_shift;
                    w_trg_nxt    = w_trg;
                    w_sel_nxt    = w_sel;
                    w_muxerr_nxt = w_mux_err;
                    w_valid_nxt  = 1'b1;
                end else begin
                    w_ferr_nxt = 1'b1;
                end
                // Envelope reopening while the old frame is being judged
                // starts the new frame immediately rather than dropping it.
                if (r_oe_rise) begin
                    w_shift_nxt = 24'd0;
                    w_cnt_nxt   = '0;
                    w_to_nxt    = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign DATA_OUT     = r_data;
    assign TRG_MASK_OUT = r_trg;
    assign JTAG_MUX_OUT = r_sel;
    assign VALID        = r_valid;
    assign FRAME_ERR    = r_ferr;
    assign MUX_ERR      = r_muxerr;

endmodule
`default_nettype wire

// File: tb/tb_led_stream_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_stream_rx
// Description : Scoreboard bench for led_stream_rx. Stimulus tasks push the
//               expected response of each frame; a monitor pops and compares
//               whenever VALID or FRAME_ERR pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_stream_rx;

    localparam int c_TIMEOUT = 1023;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LED_CLK = 1'b0;
    logic        LED_OUT = 1'b0;
    logic        LED_OE = 1'b0;
    logic [23:0] DATA_OUT;
    logic [11:0] TRG_MASK_OUT;
    logic [3:0]  JTAG_MUX_OUT;
    logic        VALID;
    logic        FRAME_ERR;
    logic        MUX_ERR;

    led_stream_rx #(
        .FRAME_BITS (24),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .LED_CLK      (LED_CLK),
        .LED_OUT      (LED_OUT),
        .LED_OE       (LED_OE),
        .DATA_OUT     (DATA_OUT),
        .TRG_MASK_OUT (TRG_MASK_OUT),
        .JTAG_MUX_OUT (JTAG_MUX_OUT),
        .VALID        (VALID),
        .FRAME_ERR    (FRAME_ERR),
        .MUX_ERR      (MUX_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [23:0] data;
        logic [11:0] trg;
        logic [3:0]  sel;
        logic        merr;
        int          exp_cyc;   // -1: latency not checked
        string       name;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // last good frame as the bench expects it
    logic [23:0] m_data = '0;
    logic [11:0] m_trg  = '0;
    logic [3:0]  m_sel  = '0;
    logic        m_merr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoder: trigger bit i and mux bit i are placed as a pair, trigger first.
    function automatic logic [23:0] encode(input logic [11:0] trg, input logic [11:0] m);
        logic [23:0] d;
        d = '0;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 4; k++) begin
                d[8*g+7-2*k] = trg[4*g+k];
                d[8*g+6-2*k] = m[4*g+k];
            end
        end
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bit(input logic b);
        LED_OUT = b;
        idle(2);
        LED_CLK = 1'b1;
        idle(4);
        LED_CLK = 1'b0;
        idle(2);
    endtask

    task automatic send_bits(input logic [23:0] word, input int nbits);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = (i < 24) ? word[23-i] : 1'b1;
            drive_bit(b);
        end
    endtask

    task automatic push_exp(input bit is_err, input int exp_cyc, input string name);
        exp_t e;
        e.is_err  = is_err;
        e.data    = m_data;
        e.trg     = m_trg;
        e.sel     = m_sel;
        e.merr    = m_merr;
        e.exp_cyc = exp_cyc;
        e.name    = name;
        sb.push_back(e);
    endtask

    task automatic close_frame(input bit is_err, input string name);
        idle(2);
        push_exp(is_err, cyc + 5, name);
        LED_OE = 1'b0;
    endtask

    task automatic good_frame(input logic [11:0] trg, input logic [11:0] m,
                              input logic [3:0] sel, input logic merr, input string name);
        logic [23:0] w;
        w = encode(trg, m);
        m_data = w;
        m_trg  = trg;
        m_sel  = sel;
        m_merr = merr;
        LED_OE = 1'b1;
        idle(4);
        send_bits(w, 24);
        close_frame(1'b0, name);
    endtask

    task automatic bad_frame(input logic [23:0] w, input int nbits, input string name);
        LED_OE = 1'b1;
        idle(4);
        send_bits(w, nbits);
        close_frame(1'b1, name);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    bit prev_pulse = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_pulse = 1'b0;
            end else begin
                if (prev_pulse) begin
                    check("pulse_width", {30'd0, VALID, FRAME_ERR}, 32'd0);
                end
                if (VALID || FRAME_ERR) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse actual valid=%0b frame_err=%0b required=none",
                                 VALID, FRAME_ERR);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_valid"}, {31'd0, VALID}, {31'd0, !e.is_err});
                        check({e.name, "_frame_err"}, {31'd0, FRAME_ERR}, {31'd0, e.is_err});
                        check({e.name, "_data"}, {8'd0, DATA_OUT}, {8'd0, e.data});
                        check({e.name, "_trg"}, {20'd0, TRG_MASK_OUT}, {20'd0, e.trg});
                        check({e.name, "_sel"}, {28'd0, JTAG_MUX_OUT}, {28'd0, e.sel});
                        check({e.name, "_mux_err"}, {31'd0, MUX_ERR}, {31'd0, e.merr});
                        if (e.exp_cyc >= 0) begin
                            check({e.name, "_latency"}, cyc, e.exp_cyc);
                        end
                    end
                end
                prev_pulse = VALID || FRAME_ERR;
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_data"}, {8'd0, DATA_OUT}, 32'd0);
        check({name, "_trg"}, {20'd0, TRG_MASK_OUT}, 32'd0);
        check({name, "_sel"}, {28'd0, JTAG_MUX_OUT}, 32'd0);
        check({name, "_pulses"}, {30'd0, VALID, FRAME_ERR}, 32'd0);
        check({name, "_mux_err"}, {31'd0, MUX_ERR}, 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int waited;
        idle(3);
        check_all_zero("reset");
        RST = 1'b0;
        idle(5);

        good_frame(12'hA5C, 12'h008, 4'd3, 1'b0, "good_a5c");
        idle(10);
        good_frame(12'h000, 12'hFFF, 4'd15, 1'b0, "mux_all_ones");
        idle(10);
        good_frame(12'h5A3, 12'h011, 4'd15, 1'b1, "mux_illegal");
        idle(10);

        bad_frame(encode(12'hFFF, 12'h040), 23, "short23");
        idle(10);
        bad_frame(encode(12'h0F0, 12'h040), 25, "long25");
        idle(10);

        // stalled frame: abort by timeout while the envelope is still open
        LED_OE = 1'b1;
        idle(4);
        push_exp(1'b1, -1, "stall");
        send_bits(encode(12'h777, 12'h002), 10);
        idle(c_TIMEOUT + 5);
        idle(10);
        LED_OE = 1'b0;
        idle(10);
        good_frame(12'h3C3, 12'h020, 4'd5, 1'b0, "after_stall");
        idle(10);

        // reset in the middle of a frame
        LED_OE = 1'b1;
        idle(4);
        send_bits(encode(12'hBEE, 12'h004), 12);
        RST = 1'b1;
        #1;
        check_all_zero("mid_reset");
        LED_OE  = 1'b0;
        LED_CLK = 1'b0;
        m_data = '0;
        m_trg  = '0;
        m_sel  = '0;
        m_merr = 1'b0;
        idle(3);
        RST = 1'b0;
        idle(5);
        good_frame(12'h123, 12'h001, 4'd0, 1'b0, "after_reset");
        idle(10);

        // back-to-back: envelope reopens one bit period after it closed
        good_frame(12'hFED, 12'h800, 4'd11, 1'b0, "b2b_1");
        idle(8);
        good_frame(12'h0F0, 12'h100, 4'd8, 1'b0, "b2b_2");

        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            idle(1);
            waited++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d_pending required=0", sb.size());
        end
        idle(30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
